// File: rtl/mos6502s_pkg.sv
// Shared definitions for the 6502 status register slice: flag bit positions,
// flag-op codes, branch-select encoding and the P packing helper.
package mos6502s_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_I = 2;
    localparam int unsigned FLAG_D = 3;
    localparam int unsigned FLAG_B = 4;
    localparam int unsigned FLAG_U = 5;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_N = 7;

    localparam logic [7:0] RESET_P_DEF = 8'h34;

    typedef enum logic [2:0] {
        FOP_NONE = 3'd0,
        FOP_CLC  = 3'd1,
        FOP_SEC  = 3'd2,
        FOP_CLI  = 3'd3,
        FOP_SEI  = 3'd4,
        FOP_CLV  = 3'd5,
        FOP_CLD  = 3'd6,
        FOP_SED  = 3'd7
    } flag_op_e;

    // br_sel[2:1] picks the tested flag; br_sel[0] is the value that takes the branch
    typedef enum logic [1:0] {
        BR_N = 2'b00,
        BR_V = 2'b01,
        BR_C = 2'b10,
        BR_Z = 2'b11
    } br_flag_e;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } p_flags_t;

    function automatic logic [7:0] pack_p(input p_flags_t f, input logic b);
        return {f.n, f.v, 1'b1, b, f.d, f.i, f.z, f.c};
    endfunction

endpackage

// File: rtl/mos6502s_int_sync.sv
// IRQ/NMI input synchronizers plus NMI falling-edge detector and pending latch.
module mos6502s_int_sync
    import mos6502s_pkg::*;
#(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_n,
    input  logic nmi_n,
    input  logic nmi_clr,
    output logic irq_act,
    output logic nmi_lat
);

    logic [SYNC_STG-1:0] irq_sync_q, irq_sync_d;
    // One stage beyond the synchronizer holds the previous synchronized NMI level
    logic [SYNC_STG:0]   nmi_sync_q, nmi_sync_d;
    logic                nmi_lat_q, nmi_lat_d;
    logic                nmi_fall;

    always_comb begin
        irq_sync_d = {irq_sync_q[SYNC_STG-2:0], irq_n};
        nmi_sync_d = {nmi_sync_q[SYNC_STG-1:0], nmi_n};
        nmi_fall   = nmi_sync_q[SYNC_STG] & ~nmi_sync_q[SYNC_STG-1];
        nmi_lat_d  = nmi_fall | (nmi_lat_q & ~nmi_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_q <= '0;
            nmi_sync_q <= '0;
            nmi_lat_q  <= 1'b0;
        end else begin
            irq_sync_q <= irq_sync_d;
            nmi_sync_q <= nmi_sync_d;
            nmi_lat_q  <= nmi_lat_d;
        end
    end

    assign irq_act = ~irq_sync_q[SYNC_STG-1];
    assign nmi_lat = nmi_lat_q;

endmodule

// File: rtl/mos6502s_status_reg.sv
// 6502 processor status register with flag ops, branch evaluation and IRQ/NMI polling.
// Define MOS6502S_DECIMAL_EN to route D to the ALU; otherwise decimal mode is forced off.
module mos6502s_status_reg
    import mos6502s_pkg::*;
#(
    parameter logic [7:0]  RESET_P  = RESET_P_DEF,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic [3:0] upd_mask,
    input  logic [2:0] flag_op,
    input  logic       pull_en,
    input  logic [7:0] pull_data,
    input  logic       pull_rti,
    input  logic       push_b,
    output logic [7:0] push_p,
    output logic       c_to_alu,
    output logic       d_to_alu,
    input  logic [2:0] br_sel,
    output logic       br_taken,
    input  logic       inst_bound,
    input  logic       irq_n,
    input  logic       nmi_n,
    output logic       int_req,
    output logic       int_is_nmi,
    input  logic       int_ack,
    output logic [7:0] p_out
);

    p_flags_t p_q, p_d;
    logic     i_poll_q, i_poll_d;
    logic     int_req_q, int_req_d;
    logic     int_is_nmi_q, int_is_nmi_d;
    logic     irq_act, nmi_lat, nmi_clr;

    mos6502s_int_sync #(.SYNC_STG(SYNC_STG)) u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_n   (irq_n),
        .nmi_n   (nmi_n),
        .nmi_clr (nmi_clr),
        .irq_act (irq_act),
        .nmi_lat (nmi_lat)
    );

    assign nmi_clr = int_ack & int_is_nmi_q;

    // Lowest priority first; later assignments override earlier ones bit by bit
    always_comb begin
        p_d = p_q;
        if (upd_mask[3]) p_d.n = alu_n;
        if (upd_mask[2]) p_d.v = alu_v;
        if (upd_mask[1]) p_d.z = alu_z;
        if (upd_mask[0]) p_d.c = alu_c;
        case (flag_op_e'(flag_op))
            FOP_CLC: p_d.c = 1'b0;
            FOP_SEC: p_d.c = 1'b1;
            FOP_CLI: p_d.i = 1'b0;
            FOP_SEI: p_d.i = 1'b1;
            FOP_CLV: p_d.v = 1'b0;
            FOP_CLD: p_d.d = 1'b0;
            FOP_SED: p_d.d = 1'b1;
            default: ;
        endcase
        if (int_ack) p_d.i = 1'b1;
        if (pull_en) begin
            p_d.n = pull_data[FLAG_N];
            p_d.v = pull_data[FLAG_V];
            p_d.d = pull_data[FLAG_D];
            p_d.i = pull_data[FLAG_I];
            p_d.z = pull_data[FLAG_Z];
            p_d.c = pull_data[FLAG_C];
        end
    end

    // Polling sees I as it stood before the boundary cycle's write; RTI bypasses that delay
    always_comb begin
        i_poll_d     = i_poll_q;
        int_req_d    = int_req_q;
        int_is_nmi_d = int_is_nmi_q;
        if (inst_bound) i_poll_d = p_q.i;
        if (pull_en && pull_rti) i_poll_d = pull_data[FLAG_I];
        if (int_ack) begin
            int_req_d    = 1'b0;
            int_is_nmi_d = 1'b0;
        end else if (inst_bound) begin
            int_req_d    = nmi_lat | (irq_act & ~i_poll_q);
            int_is_nmi_d = nmi_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q.n        <= RESET_P[FLAG_N];
            p_q.v        <= RESET_P[FLAG_V];
            p_q.d        <= RESET_P[FLAG_D];
            p_q.i        <= RESET_P[FLAG_I];
            p_q.z        <= RESET_P[FLAG_Z];
            p_q.c        <= RESET_P[FLAG_C];
            i_poll_q     <= 1'b1;
            int_req_q    <= 1'b0;
            int_is_nmi_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            i_poll_q     <= i_poll_d;
            int_req_q    <= int_req_d;
            int_is_nmi_q <= int_is_nmi_d;
        end
    end

    always_comb begin
        br_taken = 1'b0;
        case (br_flag_e'(br_sel[2:1]))
            BR_N: br_taken = (p_q.n == br_sel[0]);
            BR_V: br_taken = (p_q.v == br_sel[0]);
            BR_C: br_taken = (p_q.c == br_sel[0]);
            BR_Z: br_taken = (p_q.z == br_sel[0]);
            default: br_taken = 1'b0;
        endcase
    end

    assign p_out      = pack_p(p_q, 1'b1);
    assign push_p     = pack_p(p_q, push_b);
    assign c_to_alu   = p_q.c;
    assign int_req    = int_req_q;
    assign int_is_nmi = int_is_nmi_q;

`ifdef MOS6502S_DECIMAL_EN
    assign d_to_alu = p_q.d;
`else
    assign d_to_alu = 1'b0;
`endif

endmodule

// File: tb/tb_mos6502s_status_reg.sv
// Self-checking bench for mos6502s_status_reg: byte-level reference model,
// per-cycle compare, directed literal checks and randomized stimulus.
module tb_mos6502s_status_reg;

    localparam int unsigned SYNC = 2;

`ifdef MOS6502S_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic [3:0] upd_mask;
    logic [2:0] flag_op;
    logic       pull_en;
    logic [7:0] pull_data;
    logic       pull_rti;
    logic       push_b;
    logic [7:0] push_p;
    logic       c_to_alu, d_to_alu;
    logic [2:0] br_sel;
    logic       br_taken;
    logic       inst_bound;
    logic       irq_n, nmi_n;
    logic       int_req, int_is_nmi;
    logic       int_ack;
    logic [7:0] p_out;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    mos6502s_status_reg #(.RESET_P(8'h34), .SYNC_STG(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .upd_mask   (upd_mask),
        .flag_op    (flag_op),
        .pull_en    (pull_en),
        .pull_data  (pull_data),
        .pull_rti   (pull_rti),
        .push_b     (push_b),
        .push_p     (push_p),
        .c_to_alu   (c_to_alu),
        .d_to_alu   (d_to_alu),
        .br_sel     (br_sel),
        .br_taken   (br_taken),
        .inst_bound (inst_bound),
        .irq_n      (irq_n),
        .nmi_n      (nmi_n),
        .int_req    (int_req),
        .int_is_nmi (int_is_nmi),
        .int_ack    (int_ack),
        .p_out      (p_out)
    );

    always #5 clk = ~clk;

    // Reference model: P kept as the full debug byte (bits 5,4 always 1)
    localparam int ALU_IDX [4] = '{0, 1, 6, 7};
    localparam int FOP_IDX [8] = '{0, 0, 0, 2, 2, 6, 3, 3};
    localparam bit FOP_VAL [8] = '{0, 0, 1, 0, 1, 0, 0, 1};
    localparam int BR_IDX  [4] = '{7, 6, 0, 1};

    logic [7:0]    m_p, n_p;
    logic          m_ipoll, n_ipoll;
    logic          m_req, n_req, m_isnmi, n_isnmi, m_lat, n_lat;
    logic [SYNC-1:0] irq_h, n_irq_h;
    logic [SYNC:0]   nmi_h, n_nmi_h;
    logic [3:0]    alu_bits;

    assign alu_bits = {alu_n, alu_v, alu_z, alu_c};

    always_comb begin
        n_p = m_p;
        for (int k = 0; k < 4; k++)
            if (upd_mask[k]) n_p[ALU_IDX[k]] = alu_bits[k];
        if (flag_op != 3'd0) n_p[FOP_IDX[flag_op]] = FOP_VAL[flag_op];
        if (int_ack) n_p[2] = 1'b1;
        if (pull_en) n_p = {pull_data[7:6], 2'b11, pull_data[3:0]};

        n_ipoll = m_ipoll;
        if (inst_bound) n_ipoll = m_p[2];
        if (pull_en && pull_rti) n_ipoll = pull_data[2];

        n_lat = (nmi_h[SYNC] && !nmi_h[SYNC-1]) || (m_lat && !(int_ack && m_isnmi));

        n_req   = m_req;
        n_isnmi = m_isnmi;
        if (int_ack) begin
            n_req   = 1'b0;
            n_isnmi = 1'b0;
        end else if (inst_bound) begin
            n_req   = m_lat || (!irq_h[SYNC-1] && !m_ipoll);
            n_isnmi = m_lat;
        end

        n_irq_h = {irq_h[SYNC-2:0], irq_n};
        n_nmi_h = {nmi_h[SYNC-1:0], nmi_n};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p     <= 8'h34;
            m_ipoll <= 1'b1;
            m_req   <= 1'b0;
            m_isnmi <= 1'b0;
            m_lat   <= 1'b0;
            irq_h   <= '0;
            nmi_h   <= '0;
        end else begin
            m_p     <= n_p;
            m_ipoll <= n_ipoll;
            m_req   <= n_req;
            m_isnmi <= n_isnmi;
            m_lat   <= n_lat;
            irq_h   <= n_irq_h;
            nmi_h   <= n_nmi_h;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("p_out",      p_out,             m_p);
            check("push_p",     push_p,            {m_p[7:6], 1'b1, push_b, m_p[3:0]});
            check("c_to_alu",   {7'd0, c_to_alu},  {7'd0, m_p[0]});
            check("d_to_alu",   {7'd0, d_to_alu},  {7'd0, DEC_EN & m_p[3]});
            check("br_taken",   {7'd0, br_taken},  {7'd0, m_p[BR_IDX[br_sel[2:1]]] == br_sel[0]});
            check("int_req",    {7'd0, int_req},   {7'd0, m_req});
            check("int_is_nmi", {7'd0, int_is_nmi},{7'd0, m_isnmi});
        end
    end

    task automatic clear_ops();
        upd_mask   = 4'd0;
        flag_op    = 3'd0;
        pull_en    = 1'b0;
        pull_rti   = 1'b0;
        inst_bound = 1'b0;
        int_ack    = 1'b0;
    endtask

    // Inputs set before the call are sampled on the next rising edge, then cleared
    task automatic pulse();
        @(posedge clk);
        #1;
        clear_ops();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_n = 0; alu_z = 0; alu_c = 0; alu_v = 0;
        pull_data = 8'h00;
        push_b = 1'b1;
        br_sel = 3'd0;
        irq_n = 1'b1;
        nmi_n = 1'b1;
        clear_ops();
        cmp_en = 1'b1;

        repeat (2) @(negedge clk);
        check("rst p_out",   p_out, 8'h34);
        check("rst int_req", {7'd0, int_req}, 8'h00);
        check("rst push_p",  push_p, 8'h34);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Masked ALU update: N,Z,C written, V untouched
        upd_mask = 4'b1011; alu_n = 1; alu_z = 0; alu_c = 1; alu_v = 1;
        pulse();
        check("alu mask p_out", p_out, 8'hB5);
        br_sel = 3'b101;
        #1;
        check("bcs taken", {7'd0, br_taken}, 8'h01);
        @(posedge clk); #1;

        flag_op = 3'd7;
        pulse();
        check("sed d_to_alu", {7'd0, d_to_alu}, {7'd0, DEC_EN});
        check("sed p_out", p_out, 8'hBD);
        @(posedge clk); #1;

        // CLI takes effect for polling one instruction late
        irq_n = 1'b0;
        idle(3);
        flag_op = 3'd3;
        pulse();
        @(posedge clk); #1;
        inst_bound = 1'b1;
        pulse();
        check("cli bound1 int_req", {7'd0, int_req}, 8'h00);
        @(posedge clk); #1;
        inst_bound = 1'b1;
        pulse();
        check("cli bound2 int_req", {7'd0, int_req}, 8'h01);
        check("cli bound2 is_nmi", {7'd0, int_is_nmi}, 8'h00);
        @(posedge clk); #1;
        int_ack = 1'b1;
        pulse();
        check("irq ack int_req", {7'd0, int_req}, 8'h00);
        check("irq ack p_out", p_out, 8'hBD);

        // RTI clearing I lets a pending IRQ in at the very next boundary
        @(posedge clk); #1;
        irq_n = 1'b1;
        idle(3);
        inst_bound = 1'b1;
        pulse();
        @(posedge clk); #1;
        irq_n = 1'b0;
        idle(3);
        pull_en = 1'b1; pull_rti = 1'b1; pull_data = 8'h00;
        pulse();
        check("rti p_out", p_out, 8'h30);
        @(posedge clk); #1;
        inst_bound = 1'b1;
        pulse();
        check("rti int_req", {7'd0, int_req}, 8'h01);
        @(posedge clk); #1;
        int_ack = 1'b1;
        pulse();
        check("rti ack p_out", p_out, 8'h34);
        @(posedge clk); #1;
        irq_n = 1'b1;
        idle(3);
        inst_bound = 1'b1;
        pulse();

        // NMI ignores I and fires once per falling edge
        @(posedge clk); #1;
        nmi_n = 1'b0;
        idle(4);
        inst_bound = 1'b1;
        pulse();
        check("nmi int_req", {7'd0, int_req}, 8'h01);
        check("nmi is_nmi", {7'd0, int_is_nmi}, 8'h01);
        @(posedge clk); #1;
        int_ack = 1'b1;
        pulse();
        check("nmi ack int_req", {7'd0, int_req}, 8'h00);
        @(posedge clk); #1;
        inst_bound = 1'b1;
        pulse();
        check("nmi no retrigger", {7'd0, int_req}, 8'h00);
        @(posedge clk); #1;
        nmi_n = 1'b1;
        idle(4);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            upd_mask   = 4'($urandom);
            {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
            flag_op    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            pull_en    = ($urandom_range(0, 15) == 0);
            pull_rti   = 1'($urandom);
            pull_data  = 8'($urandom);
            push_b     = 1'($urandom);
            br_sel     = 3'($urandom);
            inst_bound = ($urandom_range(0, 3) == 0);
            int_ack    = m_req && !inst_bound && ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 19) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 14) == 0) nmi_n = ~nmi_n;
            if (cyc == 1500) begin
                #3 rst_n = 1'b0;
                push_b = 1'b1;
                @(negedge clk);
                check("midrun rst p_out",   p_out, 8'h34);
                check("midrun rst int_req", {7'd0, int_req}, 8'h00);
                check("midrun rst push_p",  push_p, 8'h34);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end

        clear_ops();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
